pc_fetch_unit: RTL and testbench

//  Program-counter register and instruction-fetch sequencer of the single-stage core; sits directly downstream of

---
 rtl/pc_fetch_unit.sv | 115 +++++++++++
 tb/tb_pc_fetch_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program-counter register and one-at-a-time instruction fetch sequencer (req/ack fetch, valid/ready issue).
// Optional build macro FETCH_COUNT_EN adds the accepted-instruction counter; otherwise fetch_count is tied to 0.
module pc_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] pc_offset,
    output logic            misalign_err,
    output logic [31:0]     fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_ERR
    } state_t;

    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic            accept;
    logic            next_misaligned;

    // Next PC is always relative to the instruction being retired, not the live PC register.
    assign accept          = (state == S_HOLD) && instr_valid && instr_ready;
    assign next_pc         = redirect_valid ? instr_pc + pc_offset : instr_pc + STEP;
    assign next_misaligned = (next_pc[1:0] != 2'b00);
    assign imem_addr       = pc;

    // NOTE: sequential state uses non-blocking <= so every register updates from pre-edge values.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            imem_req     <= 1'b0;
            instr_valid  <= 1'b0;
            instr        <= '0;
            instr_pc     <= '0;
            misalign_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!stall) begin
                        imem_req <= 1'b1;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (imem_ack) begin
                        imem_req    <= 1'b0;
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (accept) begin
                        instr_valid <= 1'b0;
                        if (next_misaligned) begin
                            misalign_err <= 1'b1;
                            state        <= S_ERR;
                        end else begin
                            pc <= next_pc;
                            if (stall) begin
                                state <= S_IDLE;
                            end else begin
                                imem_req <= 1'b1;
                                state    <= S_REQ;
                            end
                        end
                    end
                end
                default: begin
                    // Error state is terminal; only reset leaves it.
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_COUNT_EN
    logic [31:0] count_q;

    always_ff @(posedge CLK) begin
        if (reset) begin
            count_q <= '0;
        end else if (accept && !next_misaligned) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign fetch_count = count_q;
`else
    assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential fetch, redirects, misalignment, back-pressure, reset during ack,
// and PC wrap on a second instance reset to 0xFFFF_FFFC.
module tb_pc_fetch_unit;

`ifdef FETCH_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] pc_offset;
    logic        misalign_err;
    logic [31:0] fetch_count;
    logic        ack_en;

    logic        req2;
    logic [31:0] addr2;
    logic        ack2;
    logic [31:0] rdata2;
    logic        valid2;
    logic [31:0] instr2;
    logic [31:0] ipc2;
    logic        err2;
    logic [31:0] cnt2;

    int n_cmp = 0;
    int n_err = 0;
    int acc_cnt = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {8'hA5, a[23:0]};
    endfunction

    function automatic logic [31:0] exp_cnt(input int n);
        return CNT_EN ? 32'(n) : 32'd0;
    endfunction

    assign imem_ack   = ack_en & imem_req;
    assign imem_rdata = mem_word(imem_addr);
    assign ack2       = req2;
    assign rdata2     = mem_word(addr2);

    pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .PC_STEP(4)) u_dut (
        .CLK(clk), .reset(reset), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .pc_offset(pc_offset),
        .misalign_err(misalign_err), .fetch_count(fetch_count)
    );

    pc_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) u_dut_wrap (
        .CLK(clk), .reset(reset), .stall(1'b0),
        .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2), .imem_rdata(rdata2),
        .instr_valid(valid2), .instr_ready(1'b1), .instr(instr2), .instr_pc(ipc2),
        .redirect_valid(1'b0), .pc_offset(32'd0),
        .misalign_err(err2), .fetch_count(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        pc_offset      = '0;
        ack_en         = 1'b1;
        @(negedge clk);
        check("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_ipc", instr_pc, 32'h0);
        check("rst_err", misalign_err, 1'b0);
        check("rst_cnt", fetch_count, 32'h0);
        check("rst_addr_wrap", addr2, 32'hFFFF_FFFC);
        acc_cnt = 0;
        reset   = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req_seen"}, imem_req, 1'b1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!instr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid_seen"}, instr_valid, 1'b1);
        check({tag, "_no_req_with_valid"}, imem_req, 1'b0);
    endtask

    // Fetches one instruction at address a, verifies it, and sets up its accept on the next edge.
    task automatic fetch(input string tag, input logic [31:0] a, input logic rv, input logic [31:0] off);
        logic [31:0] nxt;
        wait_req(tag);
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        check({tag, "_addr"}, imem_addr, a);
        check({tag, "_cnt"}, fetch_count, exp_cnt(acc_cnt));
        @(negedge clk);
        wait_valid(tag);
        check({tag, "_ipc"}, instr_pc, a);
        check({tag, "_instr"}, instr, mem_word(a));
        redirect_valid = rv;
        pc_offset      = off;
        instr_ready    = 1'b1;
        nxt = rv ? a + off : a + 32'd4;
        if (nxt[1:0] == 2'b00) acc_cnt++;
    endtask

    initial begin
        logic [31:0] exp_a;
        reset          = 1'b1;
        stall          = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        pc_offset      = '0;
        ack_en         = 1'b1;

        // Sequential fetch with same-cycle ack, then backward and forward redirects.
        do_reset();
        fetch("t1_0", 32'h00, 1'b0, 32'h0);
        fetch("t1_4", 32'h04, 1'b0, 32'h0);
        fetch("t1_8", 32'h08, 1'b0, 32'h0);
        fetch("t1_c", 32'h0C, 1'b0, 32'h0);
        fetch("t2_back", 32'h10, 1'b1, 32'hFFFF_FFF8);
        fetch("t2_tgt8", 32'h08, 1'b0, 32'h0);
        fetch("t2_c", 32'h0C, 1'b0, 32'h0);
        fetch("t2_fwd", 32'h10, 1'b1, 32'h0000_0020);

        // Back-pressure for three cycles at 0x30, then accept while stalled.
        wait_req("t4");
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        check("t4_addr", imem_addr, 32'h30);
        @(negedge clk);
        wait_valid("t4");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_hold_valid", instr_valid, 1'b1);
            check("t4_hold_ipc", instr_pc, 32'h30);
            check("t4_hold_instr", instr, mem_word(32'h30));
            check("t4_hold_req", imem_req, 1'b0);
        end
        instr_ready = 1'b1;
        stall       = 1'b1;
        acc_cnt++;
        @(negedge clk);
        instr_ready = 1'b0;
        check("t4_valid_drop", instr_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_stall_req", imem_req, 1'b0);
        end
        stall = 1'b0;
        @(negedge clk);
        check("t4_resume_req", imem_req, 1'b1);
        check("t4_resume_addr", imem_addr, 32'h34);
        check("t4_cnt", fetch_count, exp_cnt(acc_cnt));

        // Misaligned redirect: error is sticky and fetching stops until reset.
        do_reset();
        fetch("t3", 32'h00, 1'b1, 32'h6);
        @(negedge clk);
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        check("t3_err", misalign_err, 1'b1);
        check("t3_valid", instr_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t3_req_low", imem_req, 1'b0);
            check("t3_err_sticky", misalign_err, 1'b1);
        end
        check("t3_cnt", fetch_count, exp_cnt(acc_cnt));

        // Reset arriving in the same cycle as the ack of a pending request at 0x20.
        do_reset();
        check("t3_err_cleared", misalign_err, 1'b0);
        fetch("t5_0", 32'h00, 1'b1, 32'h20);
        ack_en = 1'b0;
        @(negedge clk);
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        check("t5_pending_req", imem_req, 1'b1);
        check("t5_pending_addr", imem_addr, 32'h20);
        @(negedge clk);
        check("t5_req_held", imem_req, 1'b1);
        ack_en = 1'b1;
        reset  = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t5_valid", instr_valid, 1'b0);
        check("t5_req", imem_req, 1'b0);
        check("t5_instr", instr, 32'h0);
        check("t5_addr", imem_addr, 32'h0);
        acc_cnt = 0;
        fetch("t5_restart", 32'h00, 1'b0, 32'h0);

        // PC wrap from 0xFFFF_FFFC on the second instance, five sequential accepts.
        stall = 1'b1;
        do_reset();
        @(negedge clk);
        exp_a = 32'hFFFF_FFFC;
        for (int i = 0; i < 5; i++) begin
            check("t6_req", req2, 1'b1);
            check("t6_addr", addr2, exp_a);
            @(negedge clk);
            check("t6_valid", valid2, 1'b1);
            check("t6_ipc", ipc2, exp_a);
            check("t6_instr", instr2, mem_word(exp_a));
            @(negedge clk);
            exp_a = exp_a + 32'd4;
        end
        check("t6_addr_end", addr2, 32'h10);
        check("t6_cnt", cnt2, exp_cnt(5));
        check("t6_err", err2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
